board_writer: RTL and testbench
===============================

BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 Parameter: INIT_ROWS, default 3, number of rows per side populated by the INIT command.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-006 cmd_op  input  2  operation: 00 INIT, 01 MOVE, 10 REMOVE, 11 CLEAR.
REQ-007 src_x, src_y  input  3 each  source square column and row (0..7).
REQ-008 dst_x, dst_y  input  3 each  destination square column and row; used by MOVE only.
REQ-009 boardBuffer  output  256  registered board state consumed by the board renderer.
REQ-010 done  output  1  one-cycle pulse marking command completion.
REQ-011 error  output  1  valid with done; 1 = command rejected, boardBuffer unchanged.

Function
REQ-012 Cell index c = x + 8*y shall occupy boardBuffer[4c+3:4c]: bit0 occupied, bit1 colour (1 red, 0 green), bit2 king, bit3 always 0.
REQ-013 Dark square shall mean (x+y) even; pieces shall exist only on dark squares.
REQ-014 FSM states IDLE, INIT, EXEC, DONE; a command is accepted on a rising edge with cmd_valid && cmd_ready; op and coordinates are latched at acceptance.
REQ-015 On acceptance: INIT -> INIT state; other ops -> EXEC; cmd_valid while not IDLE is ignored and not queued.
REQ-016 INIT shall clear the whole board, then write one cell per cycle over cell counter 0..63: dark cells in rows 0..INIT_ROWS-1 = 4'h1, dark cells in rows 8-INIT_ROWS..7 = 4'h3, all others = 4'h0; after cell 63 -> DONE.
REQ-017 EXEC shall last exactly one cycle; boardBuffer updates on the edge leaving EXEC; next state DONE.
REQ-018 DONE shall last one cycle with done=1 and error valid, then return to IDLE; done=0 in all other states.
REQ-019 CLEAR shall zero all 256 bits; error=0.
REQ-020 REMOVE shall zero the src cell; error=1 if the src cell is not occupied.
REQ-021 MOVE legality: src occupied; dst unoccupied and dark; |dx| = |dy| in {1,2}; a non-king green piece requires dy>0, a non-king red piece requires dy<0; for |dx|=2 the midpoint cell shall be occupied by the opposite colour.
REQ-022 Legal MOVE: dst takes the src nibble, src cleared, midpoint cleared on a 2-step move; king bit set if a green piece lands on row 7 or a red piece on row 0.
REQ-023 Illegal MOVE (including dst == src and any dx = 0): boardBuffer unchanged, error=1.
REQ-024 Coordinate differences shall be computed signed, 4 bits wide; no wrap-around across board edges.
REQ-025 Latency: MOVE/REMOVE/CLEAR accepted at edge N -> boardBuffer updated at edge N+1, done high in cycle N+1..N+2; INIT -> done 65 cycles after acceptance.

Reset
REQ-026 Reset shall force state IDLE, boardBuffer = 256'h0, done = 0, error = 0, cell counter = 0.
REQ-027 Reset asserted in any state, including mid-INIT or DONE, shall take priority; no done pulse is produced for the aborted command.
REQ-028 cmd_ready shall be 1 in the first cycle after reset deasserts.

Verification
REQ-029 Reset, INIT -> done after 65 cycles, error=0; boardBuffer[3:0]=4'h1, [7:4]=4'h0, cell 41 [167:164]=4'h3, cell 27 [111:108]=4'h0.
REQ-030 After INIT, MOVE (2,2)->(3,3) -> cell 18 [75:72]=4'h0, cell 27 [111:108]=4'h1, error=0, done one cycle after acceptance edge.
REQ-031 After INIT, MOVE (0,0)->(1,1) (dst occupied) and red MOVE (1,5)->(2,6) (wrong direction) -> error=1 each, boardBuffer bit-identical to before.
REQ-032 INIT, MOVE (2,2)->(3,3), MOVE (5,5)->(4,4), MOVE (3,3)->(5,5) -> cells 27 and 36 = 4'h0, cell 45 [183:180]=4'h1, error=0.
REQ-033 Assert reset at INIT cycle 30 -> next cycle boardBuffer=0, cmd_ready=1, no done pulse; cmd_valid held high during EXEC/DONE -> second command is not executed.
REQ-034 REMOVE on an empty square -> error=1; CLEAR -> boardBuffer=256'h0, error=0.

Source files
------------

// File: rtl/board_writer.sv
// Checkers board state engine: executes INIT/MOVE/REMOVE/CLEAR commands against a
// 64-cell board stored as 4-bit nibbles in a registered 256-bit buffer.
module board_writer #(
  parameter int INIT_ROWS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [2:0]   src_x,
  input  logic [2:0]   src_y,
  input  logic [2:0]   dst_x,
  input  logic [2:0]   dst_y,
  output logic [255:0] boardBuffer,
  output logic         done,
  output logic         error
);

  typedef enum logic [1:0] {IDLE, INIT, EXEC, DONE} state_t;

  localparam logic [1:0] OP_INIT   = 2'b00;
  localparam logic [1:0] OP_MOVE   = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  state_t     state;
  logic [1:0] op_q;
  logic [2:0] sx_q, sy_q, dx_q, dy_q;
  logic [5:0] cell_q;
  logic       clr_q;

  function automatic logic [3:0] init_nibble(input logic [5:0] c);
    logic [2:0] x;
    logic [2:0] y;
    x = c[2:0];
    y = c[5:3];
    if (x[0] != y[0])               return 4'h0;
    if (int'(y) < INIT_ROWS)        return 4'h1;
    if (int'(y) >= 8 - INIT_ROWS)   return 4'h3;
    return 4'h0;
  endfunction

  function automatic logic [3:0] abs4(input logic signed [3:0] v);
    return v[3] ? 4'(-v) : 4'(v);
  endfunction

  assign cmd_ready = (state == IDLE);

  // Move evaluation from the latched command
  logic signed [3:0] ddx, ddy;
  logic [3:0] adx, ady;
  logic [2:0] mx, my;
  logic [5:0] sc, dc, mc;
  logic [3:0] snib, dnib, mnib, mvnib;
  logic       dir_ok, jump_ok, legal, promote;

  always_comb begin
    ddx     = $signed({1'b0, dx_q}) - $signed({1'b0, sx_q});
    ddy     = $signed({1'b0, dy_q}) - $signed({1'b0, sy_q});
    adx     = abs4(ddx);
    ady     = abs4(ddy);
    mx      = 3'(({1'b0, sx_q} + {1'b0, dx_q}) >> 1);
    my      = 3'(({1'b0, sy_q} + {1'b0, dy_q}) >> 1);
    sc      = {sy_q, sx_q};
    dc      = {dy_q, dx_q};
    mc      = {my, mx};
    snib    = boardBuffer[{sc, 2'b00} +: 4];
    dnib    = boardBuffer[{dc, 2'b00} +: 4];
    mnib    = boardBuffer[{mc, 2'b00} +: 4];
    dir_ok  = snib[2] || (snib[1] ? (ddy < 4'sd0) : (ddy > 4'sd0));
    jump_ok = (adx != 4'd2) || (mnib[0] && (mnib[1] != snib[1]));
    legal   = snib[0] && !dnib[0] && (dx_q[0] == dy_q[0]) && (adx == ady) &&
              (adx == 4'd1 || adx == 4'd2) && dir_ok && jump_ok;
    promote = snib[1] ? (dy_q == 3'd0) : (dy_q == 3'd7);
    mvnib   = {1'b0, snib[2] | promote, snib[1], 1'b1};
  end

  // Command FSM and board update
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      boardBuffer <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      cell_q      <= '0;
      clr_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            op_q <= cmd_op;
            sx_q <= src_x;
            sy_q <= src_y;
            dx_q <= dst_x;
            dy_q <= dst_y;
            if (cmd_op == OP_INIT) begin
              state  <= INIT;
              clr_q  <= 1'b1;
              cell_q <= '0;
            end else begin
              state <= EXEC;
            end
          end
        end
        INIT: begin
          if (clr_q) begin
            boardBuffer <= '0;
            clr_q       <= 1'b0;
          end else begin
            boardBuffer[{cell_q, 2'b00} +: 4] <= init_nibble(cell_q);
            cell_q <= cell_q + 6'd1;
            if (cell_q == 6'd63) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b0;
            end
          end
        end
        EXEC: begin
          state <= DONE;
          done  <= 1'b1;
          error <= 1'b0;
          case (op_q)
            OP_CLEAR: boardBuffer <= '0;
            OP_REMOVE: begin
              if (snib[0]) boardBuffer[{sc, 2'b00} +: 4] <= 4'h0;
              else         error <= 1'b1;
            end
            OP_MOVE: begin
              if (legal) begin
                boardBuffer[{sc, 2'b00} +: 4] <= 4'h0;
                if (adx == 4'd2) boardBuffer[{mc, 2'b00} +: 4] <= 4'h0;
                boardBuffer[{dc, 2'b00} +: 4] <= mvnib;
              end else begin
                error <= 1'b1;
              end
            end
            default: error <= 1'b1;
          endcase
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Bench for board_writer: directed scenarios plus randomized commands checked
// against a cell-array reference model of the checkers rules.
module tb_board_writer;

  logic         clk = 1'b0;
  logic         reset, cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   src_x, src_y, dst_x, dst_y;
  logic [255:0] boardBuffer;
  logic         done, error;

  int checks = 0;
  int failures = 0;
  logic [3:0] m [64];

  always #5 clk = ~clk;

  board_writer #(.INIT_ROWS(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .boardBuffer(boardBuffer), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] packed_model();
    logic [255:0] p;
    for (int i = 0; i < 64; i++) p[4*i +: 4] = m[i];
    return p;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input int op, input int sx, input int sy, input int dx, input int dy,
                       output int err);
    int s, d, mi, ax, ay, ddx, ddy;
    logic [3:0] sn, dn, mn;
    logic ok;
    err = 0;
    case (op)
      0: for (int y = 0; y < 8; y++)
           for (int x = 0; x < 8; x++)
             m[x + 8*y] = ((x + y) % 2 != 0) ? 4'h0 : (y < 3) ? 4'h1 : (y >= 5) ? 4'h3 : 4'h0;
      1: begin
        s = sx + 8*sy;  d = dx + 8*dy;
        sn = m[s];  dn = m[d];
        ddx = dx - sx;  ddy = dy - sy;
        ax = iabs(ddx);  ay = iabs(ddy);
        ok = sn[0] && !dn[0] && ((dx + dy) % 2 == 0) && ax == ay && (ax == 1 || ax == 2);
        if (ok && !sn[2]) ok = sn[1] ? (ddy < 0) : (ddy > 0);
        mi = (sx + dx) / 2 + 8 * ((sy + dy) / 2);
        if (ok && ax == 2) begin
          mn = m[mi];
          ok = mn[0] && (mn[1] != sn[1]);
        end
        if (!ok) err = 1;
        else begin
          if ((!sn[1] && dy == 7) || (sn[1] && dy == 0)) sn[2] = 1'b1;
          m[s] = 4'h0;
          if (ax == 2) m[mi] = 4'h0;
          m[d] = sn;
        end
      end
      2: if (!m[sx + 8*sy][0]) err = 1; else m[sx + 8*sy] = 4'h0;
      default: for (int i = 0; i < 64; i++) m[i] = 4'h0;
    endcase
  endtask

  task automatic issue(input int op, input int sx, input int sy, input int dx, input int dy,
                       input string tag);
    int n, exp_err;
    check({tag, " ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op[1:0];
    src_x = sx[2:0]; src_y = sy[2:0]; dst_x = dx[2:0]; dst_y = dy[2:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model(op, sx, sy, dx, dy, exp_err);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, (op == 0) ? 65 : 1);
    check({tag, " error"}, error, exp_err);
    check({tag, " board"}, boardBuffer, packed_model());
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) m[i] = 4'h0;
  endtask

  initial begin
    int dcount, sx, sy, dx, dy, k, r, idx;
    int occ [$];
    cmd_op = 2'b00; src_x = 0; src_y = 0; dst_x = 0; dst_y = 0;
    do_reset();
    check("rst board", boardBuffer, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst ready", cmd_ready, 1);

    issue(0, 0, 0, 0, 0, "init");
    check("init c0", boardBuffer[3:0], 4'h1);
    check("init c1", boardBuffer[7:4], 4'h0);
    check("init c41", boardBuffer[167:164], 4'h3);
    check("init c27", boardBuffer[111:108], 4'h0);

    issue(1, 2, 2, 3, 3, "mv22_33");
    check("mv c18", boardBuffer[75:72], 4'h0);
    check("mv c27", boardBuffer[111:108], 4'h1);
    issue(1, 0, 0, 1, 1, "mv dst occupied");
    issue(1, 1, 5, 2, 6, "mv red backward");
    issue(1, 0, 2, 0, 2, "mv same square");
    issue(1, 7, 1, 0, 2, "mv edge wrap");

    issue(0, 0, 0, 0, 0, "init2");
    issue(1, 2, 2, 3, 3, "j1");
    issue(1, 5, 5, 4, 4, "j2");
    issue(1, 3, 3, 5, 5, "jump");
    check("jump c27", boardBuffer[111:108], 4'h0);
    check("jump c36", boardBuffer[147:144], 4'h0);
    check("jump c45", boardBuffer[183:180], 4'h1);
    issue(2, 3, 3, 0, 0, "remove empty");
    issue(2, 5, 7, 0, 0, "remove red");
    issue(3, 0, 0, 0, 0, "clear");
    check("clear board", boardBuffer, 0);

    // green piece walks to row 7 and is crowned
    issue(0, 0, 0, 0, 0, "init3");
    issue(1, 2, 2, 3, 3, "k1");
    issue(1, 3, 3, 4, 4, "k2");
    issue(2, 5, 5, 0, 0, "k3");
    issue(1, 4, 4, 5, 5, "k4");
    issue(2, 6, 6, 0, 0, "k5");
    issue(1, 5, 5, 6, 6, "k6");
    issue(2, 7, 7, 0, 0, "k7");
    issue(1, 6, 6, 7, 7, "crown");
    check("crown c63", boardBuffer[255:252], 4'h5);
    issue(1, 7, 7, 6, 6, "king back");

    // reset in the middle of INIT
    issue(0, 0, 0, 0, 0, "init4");
    cmd_valid = 1'b1; cmd_op = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) m[i] = 4'h0;
    check("abort board", boardBuffer, 0);
    check("abort ready", cmd_ready, 1);
    repeat (70) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort no done", dcount, 0);

    // cmd_valid held through EXEC/DONE must not start a second command
    issue(0, 0, 0, 0, 0, "init5");
    cmd_valid = 1'b1; cmd_op = 2'b10; src_x = 0; src_y = 0;
    @(posedge clk); #1;
    src_x = 2;
    check("hold ready exec", cmd_ready, 0);
    @(posedge clk); #1;
    check("hold done", done, 1);
    check("hold ready done", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m[0] = 4'h0;
    check("hold board", boardBuffer, packed_model());
    @(posedge clk); #1;
    check("hold no 2nd", boardBuffer, packed_model());
    check("hold no done", done, 0);

    // randomized command stream
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(99);
      occ.delete();
      for (int i = 0; i < 64; i++) if (m[i][0]) occ.push_back(i);
      if (occ.size() == 0 || r < 4) begin
        issue(0, 0, 0, 0, 0, "rnd init");
      end else if (r < 7) begin
        issue(3, 0, 0, 0, 0, "rnd clear");
      end else if (r < 17) begin
        issue(2, $urandom_range(7), $urandom_range(7), 0, 0, "rnd remove");
      end else if (r < 27) begin
        issue(1, $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7),
              "rnd move any");
      end else begin
        idx = occ[$urandom_range(occ.size() - 1)];
        sx = idx % 8;  sy = idx / 8;
        k = $urandom_range(1, 2);
        dx = (sx + ($urandom_range(1) ? k : -k)) & 7;
        dy = (sy + ($urandom_range(1) ? k : -k)) & 7;
        issue(1, sx, sy, dx, dy, "rnd move diag");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
